// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor slice plus a registered
// borrow. It handles one bit per clock and holds the result until the next accepted start.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bor,
  output logic [1:0]       fsm_state
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Handshake: start is a level request. It is honoured on a rising edge when the
  // block is in IDLE or DONE, and ignored in RUN. done is a one-cycle valid strobe
  // for D/Bor, and there is no backpressure.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, part;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic             a_bit, b_bit, diff, bout, accept, last;

  assign a_bit     = a_sr[0];
  assign b_bit     = b_sr[0];
  assign diff      = a_bit ^ b_bit ^ bin;
  assign bout      = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
  assign accept    = start && (state_q != RUN);
  assign last      = (cnt == LAST);
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      part    <= '0;
      bin     <= 1'b0;
      cnt     <= '0;
      D       <= '0;
      Bor     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sr <= A;
        b_sr <= B;
        bin  <= 1'b0;
        cnt  <= '0;
      end else if (state_q == RUN) begin
        // LSB-first: each new difference bit enters at the top, so after WIDTH bits part is aligned.
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        part <= {diff, part[WIDTH-1:1]};
        bin  <= bout;
        cnt  <= cnt + CW'(1);
        if (last) begin
          D   <= {diff, part[WIDTH-1:1]};
          Bor <= bout;
        end
      end
    end
  end
endmodule
